pixel_frame_writer: RTL and testbench

- Downstream consumer of the camera controller's pixel stream (newPixel strobe plus 16-bit RGB565 pixelData).
- Frames the stream using vsync, optionally decimates 2:1 in both axes, and buffers accepted pixels in a small FIFO.
- Emits linear-address writes to a frame-buffer memory port that applies backpressure (memReady).
- Signals frame completion to the display/readout side.

---
 rtl/pixel_frame_writer.sv | 152 +++++++++++++++
 tb/tb_pixel_frame_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_writer.sv
// Frames a camera pixel stream on vsync, optionally decimates 2:1, and writes
// kept pixels through a small FIFO to a backpressured linear frame buffer.
module pixel_frame_writer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int DECIMATE   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              vsync,
  input  logic              newPixel,
  input  logic [15:0]       pixelData,
  input  logic              memReady,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddr,
  output logic [15:0]       memData,
  output logic              capturing,
  output logic              frameDone,
  output logic              overflow
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = ADDR_W + 16;

  localparam longint unsigned KEPT_PIXELS =
    longint'(H_ACTIVE) * longint'(V_ACTIVE) / longint'(DECIMATE * DECIMATE);
  localparam longint unsigned ADDR_SPACE = 64'd1 << ADDR_W;

  if (KEPT_PIXELS > ADDR_SPACE) begin : g_addr_check
    $error("pixel_frame_writer: frame does not fit in ADDR_W address bits");
  end
  if (DECIMATE != 1 && DECIMATE != 2) begin : g_dec_check
    $error("pixel_frame_writer: DECIMATE must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("pixel_frame_writer: FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              vsync_p1;
  logic              vsync_rise, vsync_fall;
  logic [XW-1:0]     x_in;
  logic [YW-1:0]     y_in;
  logic [ADDR_W-1:0] wr_addr;
  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              fifo_empty, fifo_full;
  logic              pix_in, last_x, last_y, keep, pop, push_ok, drop, start_frame;

  assign vsync_rise  = vsync & ~vsync_p1;
  assign vsync_fall  = ~vsync & vsync_p1;
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CW'(FIFO_DEPTH));
  assign pix_in      = (state_q == CAPTURE) && newPixel;
  assign last_x      = (x_in == XW'(H_ACTIVE - 1));
  assign last_y      = (y_in == YW'(V_ACTIVE - 1));
  assign keep        = pix_in && ((DECIMATE == 1) || (!x_in[0] && !y_in[0]));
  assign pop         = memWrite && memReady;
  assign push_ok     = keep && (!fifo_full || pop);
  assign drop        = keep && fifo_full && !pop;
  assign start_frame = (state_q == ARMED) && vsync_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      vsync_p1 <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsync_p1 <= vsync;
    end
  end

  always_comb begin
    state_d   = state_q;
    frameDone = 1'b0;
    case (state_q)
      IDLE:    if (vsync_rise && enable) state_d = ARMED;
      ARMED:   if (vsync_fall) state_d = CAPTURE;
      CAPTURE: if ((pix_in && last_x && last_y) || vsync_rise) state_d = DRAIN;
      DRAIN: begin
        // Head register empty means the last write has already been accepted.
        if (fifo_empty) begin
          frameDone = 1'b1;
          state_d   = enable ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign capturing = (state_q == CAPTURE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_in     <= '0;
      y_in     <= '0;
      wr_addr  <= '0;
      overflow <= 1'b0;
    end else if (start_frame) begin
      x_in     <= '0;
      y_in     <= '0;
      wr_addr  <= '0;
      overflow <= 1'b0;
    end else if (pix_in) begin
      if (last_x) begin
        x_in <= '0;
        y_in <= y_in + YW'(1);
      end else begin
        x_in <= x_in + XW'(1);
      end
      // Dropped pixels still consume an address so later pixels land correctly.
      if (keep) wr_addr <= wr_addr + ADDR_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {wr_addr, pixelData};
  end

  assign head     = fifo_mem[rd_ptr];
  assign memWrite = !fifo_empty;
  assign memAddr  = memWrite ? head[EW-1:16] : '0;
  assign memData  = memWrite ? head[15:0] : '0;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Drives two writers (full rate and 2:1 decimated) with the same camera stream
// and compares every cycle against a queue-based model of the expected writes.
module tb_pixel_frame_writer;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 17;

  logic          clk = 1'b0;
  logic          reset, enable, vsync, newPixel, memReady;
  logic [15:0]   pixelData;
  logic [1:0]    mw, cap, fd, ov;
  logic [AW-1:0] ma0, ma1;
  logic [15:0]   md0, md1;

  int n_chk = 0, n_pass = 0;
  int rdy_mode = 0;
  bit in_frame = 0, start_pulse = 0, full_frame = 0;
  int cyc = 0;
  int qa [2][64];
  int qd [2][64];
  int qh [2], qt [2], k [2], nfd [2], last_wr [2];
  bit ovf [2];

  always #5 clk = ~clk;

  pixel_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIMATE(1), .FIFO_DEPTH(DEPTH),
                       .ADDR_W(AW)) u_dec1 (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .newPixel(newPixel),
    .pixelData(pixelData), .memReady(memReady), .memWrite(mw[0]), .memAddr(ma0),
    .memData(md0), .capturing(cap[0]), .frameDone(fd[0]), .overflow(ov[0]));

  pixel_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIMATE(2), .FIFO_DEPTH(DEPTH),
                       .ADDR_W(AW)) u_dec2 (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .newPixel(newPixel),
    .pixelData(pixelData), .memReady(memReady), .memWrite(mw[1]), .memAddr(ma1),
    .memData(md1), .capturing(cap[1]), .frameDone(fd[1]), .overflow(ov[1]));

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Expected FIFO behaviour: pop when head offered and ready, then push kept pixel
  // unless the queue is still full; address follows from pixel position alone.
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int d, x, y;
      bit popped;
      if (!reset) begin
        qh[i] = 0; qt[i] = 0; ovf[i] = 0; k[i] = 0;
      end else begin
        popped = (qt[i] - qh[i] > 0) && memReady;
        if (popped) begin
          qh[i]++;
          last_wr[i] = cyc;
        end
        if (start_pulse) begin
          k[i] = 0; ovf[i] = 0;
        end else if (in_frame && newPixel) begin
          d = i + 1; x = k[i] % H; y = k[i] / H;
          if (d == 1 || (x % 2 == 0 && y % 2 == 0)) begin
            if (qt[i] - qh[i] == DEPTH) ovf[i] = 1;
            else begin
              qa[i][qt[i] % 64] = (y / d) * (H / d) + x / d;
              qd[i][qt[i] % 64] = int'(pixelData);
              qt[i]++;
            end
          end
          k[i]++;
        end
      end
    end
    cyc++;
  endtask

  task automatic model_check();
    for (int i = 0; i < 2; i++) begin
      int sz;
      int a_obs, d_obs;
      sz = qt[i] - qh[i];
      a_obs = (i == 0) ? int'(ma0) : int'(ma1);
      d_obs = (i == 0) ? int'(md0) : int'(md1);
      check(i ? "d2_memWrite" : "d1_memWrite", int'(mw[i]), int'(sz > 0));
      if (sz > 0) begin
        check(i ? "d2_memAddr" : "d1_memAddr", a_obs, qa[i][qh[i] % 64]);
        check(i ? "d2_memData" : "d1_memData", d_obs, qd[i][qh[i] % 64]);
      end
      check(i ? "d2_overflow" : "d1_overflow", int'(ov[i]), int'(ovf[i]));
      if (fd[i]) begin
        nfd[i]++;
        check(i ? "d2_fd_empty" : "d1_fd_empty", sz, 0);
        if (full_frame && i == 0) check("d1_fd_latency", cyc - last_wr[i], 1);
      end
    end
  endtask

  task automatic tick();
    case (rdy_mode)
      0: memReady = 1'b1;
      1: memReady = 1'($urandom_range(1, 0));
      2: memReady = 1'b0;
      default: memReady = ~memReady;
    endcase
    @(posedge clk);
    model_update();
    @(negedge clk);
    if (reset) model_check();
  endtask

  task automatic frame(input int npix, input bit short_fr, input bit idx_data,
                       input int gap_max, input int hold_n);
    int b0, b1, n, mode_save;
    b0 = nfd[0]; b1 = nfd[1];
    full_frame = !short_fr;
    if (!vsync) begin
      vsync = 1'b1; tick(); tick();
    end else tick();
    vsync = 1'b0; start_pulse = 1; tick(); start_pulse = 0;
    check("cap_start", int'(cap), 3);
    mode_save = rdy_mode;
    if (hold_n > 0) rdy_mode = 2;
    in_frame = 1;
    for (int p = 0; p < npix; p++) begin
      int g;
      g = int'($urandom_range(gap_max, 0));
      repeat (g) tick();
      if (hold_n > 0 && p == hold_n) rdy_mode = mode_save;
      newPixel = 1'b1;
      pixelData = idx_data ? 16'(p) : 16'($urandom);
      tick();
      newPixel = 1'b0;
    end
    in_frame = 0;
    rdy_mode = mode_save;
    if (short_fr) begin
      vsync = 1'b1; tick();
    end
    n = 0;
    while ((nfd[0] == b0 || nfd[1] == b1) && n < 300) begin
      tick(); n++;
    end
    check("fd_timeout", int'(n < 300), 1);
    repeat (3) tick();
    check("d1_fd_count", nfd[0] - b0, 1);
    check("d2_fd_count", nfd[1] - b1, 1);
    check("cap_end", int'(cap), 0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; vsync = 1'b0; newPixel = 1'b0;
    pixelData = '0; memReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      qh[i] = 0; qt[i] = 0; k[i] = 0; nfd[i] = 0; last_wr[i] = 0; ovf[i] = 0;
    end
    tick(); tick();
    check("rst_memWrite", int'(mw), 0);
    check("rst_capturing", int'(cap), 0);
    check("rst_frameDone", int'(fd), 0);
    check("rst_overflow", int'(ov), 0);
    check("rst_memAddr", int'(ma0), 0);
    check("rst_memData", int'(md1), 0);
    reset = 1'b1;
    tick();

    // Full frame, index data, memory always ready.
    frame(32, 0, 1, 0, 0);
    // Memory stalled for the first six pixels: full-rate writer must drop two.
    frame(32, 0, 1, 0, 6);
    check("d1_ovf_sticky", int'(ov[0]), 1);
    check("d2_ovf_clear", int'(ov[1]), 0);
    // Short frame with memReady toggling each cycle.
    rdy_mode = 3;
    frame(10, 1, 1, 1, 0);
    check("ovf_after_short", int'(ov), 0);
    // Random data, random gaps, random backpressure.
    rdy_mode = 1;
    for (int f = 0; f < 4; f++) begin
      bit sh;
      sh = (f == 2);
      frame(sh ? int'($urandom_range(28, 3)) : 32, sh, 0, 2, 0);
    end

    // Reset mid-capture with three entries queued in the full-rate writer.
    rdy_mode = 0;
    if (vsync) begin vsync = 1'b0; tick(); end
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0; start_pulse = 1; tick(); start_pulse = 0;
    rdy_mode = 2; in_frame = 1;
    for (int p = 0; p < 3; p++) begin
      newPixel = 1'b1; pixelData = 16'($urandom); tick(); newPixel = 1'b0;
    end
    tick();
    check("pre_rst_queued", int'(mw[0]), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_memWrite", int'(mw), 0);
    check("rst_mid_capturing", int'(cap), 0);
    check("rst_mid_frameDone", int'(fd), 0);
    in_frame = 0;
    tick();
    reset = 1'b1; rdy_mode = 0;
    for (int p = 0; p < 4; p++) begin
      newPixel = 1'b1; pixelData = 16'($urandom); tick(); newPixel = 1'b0; tick();
    end
    check("post_rst_idle", int'(cap), 0);

    // vsync pulse with enable low must not arm capture.
    enable = 1'b0;
    vsync = 1'b1; tick(); tick();
    vsync = 1'b0; tick();
    for (int p = 0; p < 5; p++) begin
      newPixel = 1'b1; pixelData = 16'($urandom); tick(); newPixel = 1'b0;
    end
    repeat (3) tick();
    check("disabled_cap", int'(cap), 0);
    enable = 1'b1;

    rdy_mode = 3;
    frame(32, 0, 0, 1, 0);
    rdy_mode = 1;
    frame(32, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
